// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory port arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/memory.
interface mem_port_arbiter_if;
   logic [1:0]  rq_valid;
   logic [63:0] rq_addr;
   logic [1:0]  rq_we;
   logic [63:0] rq_wdata;
   logic [1:0]  rq_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        busy;

   modport master (
      input  rq_valid, rq_addr, rq_we, rq_wdata, mem_ready, mem_rsp_valid, mem_rsp_rdata,
      output rq_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_addr, mem_we, mem_wdata, busy
   );

   modport slave (
      output rq_valid, rq_addr, rq_we, rq_wdata, mem_ready, mem_rsp_valid, mem_rsp_rdata,
      input  rq_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single variable-latency memory port.
// One transaction in flight at a time; a response timeout converts a hung
// memory into an error response so the core never stalls forever.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   // Counter value on which the timeout fires (only meaningful when TIMEOUT != 0)
   localparam int unsigned TO_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [15:0] TO_LAST16 = 16'(TO_LAST);

   state_t      r_state;
   state_t      w_next;
   logic        r_last_grant;
   logic        r_owner;
   logic [31:0] r_addr;
   logic        r_we;
   logic [31:0] r_wdata;
   logic [15:0] r_cnt;
   logic [1:0]  r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic [1:0]  w_grant;
   logic        w_grant_any;
   logic        w_accept;
   logic        w_timeout;
   logic        w_rsp_hit;
   logic        w_rsp_to;
   logic [1:0]  w_rq_ready;
   logic        w_mem_valid;
   logic        w_busy;

   // Round-robin pick: a lone requester wins, on a tie the one not served last wins
   always_comb begin
      w_grant = 2'b00;
      case (bus.rq_valid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
   end

   assign w_grant_any = (r_state == S_IDLE) && (w_grant != 2'b00);
   assign w_accept    = (r_state == S_CMD) && bus.mem_ready;
   assign w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST16);
   // A response arriving on the timeout cycle takes priority over the error
   assign w_rsp_hit   = (r_state == S_RSP) && bus.mem_rsp_valid;
   assign w_rsp_to    = (r_state == S_RSP) && !bus.mem_rsp_valid && w_timeout;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant != 2'b00) w_next = S_CMD;
         S_CMD:   if (bus.mem_ready) w_next = S_RSP;
         S_RSP:   if (bus.mem_rsp_valid || w_timeout) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State-decoded outputs; rq_ready is held low while reset is asserted
   always_comb begin
      w_rq_ready  = 2'b00;
      w_mem_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (!reset) w_rq_ready = w_grant;
         end
         S_CMD:   w_mem_valid = 1'b1;
         S_RSP:   w_mem_valid = 1'b0;
         default: w_busy = 1'b0;
      endcase
   end

   // Capture the winning request and remember who was served
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
      end else if (w_grant_any) begin
         r_last_grant <= w_grant[1];
         r_owner      <= w_grant[1];
         r_addr       <= w_grant[1] ? bus.rq_addr[63:32]  : bus.rq_addr[31:0];
         r_we         <= w_grant[1] ? bus.rq_we[1]        : bus.rq_we[0];
         r_wdata      <= w_grant[1] ? bus.rq_wdata[63:32] : bus.rq_wdata[31:0];
      end
   end

   // Response wait counter: cleared on command accept, counts RSP cycles, saturates
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if ((r_state == S_RSP) && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // Registered single-cycle response pulse to the transaction owner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= 2'b00;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 2'b00;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         if (w_rsp_hit) begin
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_rsp_rdata <= r_we ? 32'd0 : bus.mem_rsp_rdata;
         end else if (w_rsp_to) begin
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_rsp_err   <= 1'b1;
         end
      end
   end

   assign bus.rq_ready  = w_rq_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.mem_valid = w_mem_valid;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_we    = r_we;
   assign bus.mem_wdata = r_wdata;
   assign bus.busy      = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant choice, latency, timeout outcome).
module tb_mem_port_arbiter;
   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   m_last;   // model: requester served most recently

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus_a ();
   mem_port_arbiter_if bus_b ();

   mem_port_arbiter #(.TIMEOUT(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   mem_port_arbiter #(.TIMEOUT(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   localparam int T_A = 4;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus_a.rq_valid = '0; bus_a.rq_addr = '0; bus_a.rq_we = '0; bus_a.rq_wdata = '0;
      bus_a.mem_ready = 1'b0; bus_a.mem_rsp_valid = 1'b0; bus_a.mem_rsp_rdata = '0;
      bus_b.rq_valid = '0; bus_b.rq_addr = '0; bus_b.rq_we = '0; bus_b.rq_wdata = '0;
      bus_b.mem_ready = 1'b0; bus_b.mem_rsp_valid = 1'b0; bus_b.mem_rsp_rdata = '0;
   endtask

   task automatic test_reset();
      logic [135:0] outs;
      clear_inputs();
      reset = 1'b1;
      bus_a.rq_valid = 2'b11;
      bus_a.rq_addr  = 64'h0000_0B00_0000_0A00;
      tick(); tick();
      #1;
      outs = {bus_a.rq_ready, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, bus_a.mem_valid,
              bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata, bus_a.busy};
      total++;
      if (outs !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h required 0", outs);
      end
      @(negedge clk);
      reset = 1'b0;
      m_last = 1;
   endtask

   task automatic test_contention();
      logic [1:0]  exp_g;
      logic [1:0]  prev_g;
      logic [31:0] prev_d;
      logic [31:0] d;
      // still in the post-reset cycle, both requesters valid
      bus_a.mem_ready = 1'b1;
      bus_a.rq_we = 2'b00;
      prev_g = 2'b00;
      prev_d = '0;
      for (int n = 0; n < 6; n++) begin
         exp_g = (m_last == 1) ? 2'b01 : 2'b10;
         bus_a.mem_rsp_valid = 1'b0;
         #1;
         total++;
         if ({bus_a.rq_ready, bus_a.rsp_valid, bus_a.rsp_rdata} !== {exp_g, prev_g, prev_d}) begin
            bad++;
            $display("FAIL contention_grant n=%0d: rq_ready=%b rsp_valid=%b rdata=%h required %b %b %h",
                     n, bus_a.rq_ready, bus_a.rsp_valid, bus_a.rsp_rdata, exp_g, prev_g, prev_d);
         end
         tick();
         m_last = exp_g[1];
         total++;
         if ({bus_a.mem_valid, bus_a.rq_ready, bus_a.mem_addr} !==
             {1'b1, 2'b00, (exp_g[1] ? 32'h0000_0B00 : 32'h0000_0A00)}) begin
            bad++;
            $display("FAIL contention_cmd n=%0d: mem_valid=%b rq_ready=%b addr=%h", n,
                     bus_a.mem_valid, bus_a.rq_ready, bus_a.mem_addr);
         end
         tick();
         d = $urandom;
         bus_a.mem_rsp_valid = 1'b1;
         bus_a.mem_rsp_rdata = d;
         #1;
         total++;
         if ({bus_a.rq_ready, bus_a.mem_valid} !== 3'b000) begin
            bad++; $display("FAIL contention_rsp n=%0d: rq_ready=%b mem_valid=%b", n,
                            bus_a.rq_ready, bus_a.mem_valid);
         end
         tick();
         prev_g = exp_g;
         prev_d = d;
      end
      bus_a.mem_rsp_valid = 1'b0;
      bus_a.rq_valid = 2'b00;
      bus_a.mem_ready = 1'b0;
      #1;
      total++;
      if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rq_ready} !== {prev_g, prev_d, 2'b00}) begin
         bad++; $display("FAIL contention_last: rsp_valid=%b rdata=%h required %b %h",
                         bus_a.rsp_valid, bus_a.rsp_rdata, prev_g, prev_d);
      end
      tick();
   endtask

   task automatic test_single_read();
      bus_a.rq_valid = 2'b01; bus_a.rq_addr = 64'h0000_0000_0000_0100; bus_a.rq_we = 2'b00;
      #1;
      total++;
      if (bus_a.rq_ready !== 2'b01) begin
         bad++; $display("FAIL read_grant: got %b required 01", bus_a.rq_ready);
      end
      tick();
      m_last = 0;
      bus_a.rq_valid = 2'b00; bus_a.mem_ready = 1'b1;
      #1;
      total++;
      if ({bus_a.mem_valid, bus_a.mem_addr, bus_a.mem_we, bus_a.rsp_valid} !== {1'b1, 32'h100, 1'b0, 2'b00}) begin
         bad++; $display("FAIL read_cmd: valid=%b addr=%h we=%b", bus_a.mem_valid, bus_a.mem_addr, bus_a.mem_we);
      end
      tick();
      bus_a.mem_ready = 1'b0; bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_rdata = 32'h1234_5678;
      #1;
      total++;
      if ({bus_a.mem_valid, bus_a.busy, bus_a.rsp_valid} !== 4'b0100) begin
         bad++; $display("FAIL read_rspwait: mem_valid=%b busy=%b", bus_a.mem_valid, bus_a.busy);
      end
      tick();
      bus_a.mem_rsp_valid = 1'b0;
      #1;
      total++;
      if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, bus_a.busy} !== {2'b01, 32'h1234_5678, 1'b0, 1'b0}) begin
         bad++; $display("FAIL read_rsp: valid=%b rdata=%h err=%b", bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err);
      end
      tick();
      total++;
      if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err} !== '0) begin
         bad++; $display("FAIL read_pulse_end: valid=%b rdata=%h", bus_a.rsp_valid, bus_a.rsp_rdata);
      end
   endtask

   task automatic test_write_bp();
      bus_a.rq_valid = 2'b10; bus_a.rq_addr = 64'h0000_2000_0000_0444; bus_a.rq_we = 2'b10;
      bus_a.rq_wdata = 64'hCAFE_F00D_1111_1111;
      #1;
      total++;
      if (bus_a.rq_ready !== 2'b10) begin
         bad++; $display("FAIL write_grant: got %b required 10", bus_a.rq_ready);
      end
      tick();
      m_last = 1;
      bus_a.rq_valid = 2'b00; bus_a.rq_addr = {$urandom, $urandom}; bus_a.rq_wdata = {$urandom, $urandom};
      bus_a.rq_we = 2'b01;
      for (int c = 0; c < 5; c++) begin
         bus_a.mem_ready = (c == 4);
         #1;
         total++;
         if ({bus_a.mem_valid, bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata} !==
             {1'b1, 32'h2000, 1'b1, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL write_cmd c=%0d: valid=%b addr=%h we=%b wdata=%h", c,
                            bus_a.mem_valid, bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata);
         end
         tick();
      end
      bus_a.mem_ready = 1'b0; bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_rdata = 32'hDEAD_BEEF;
      tick();
      bus_a.mem_rsp_valid = 1'b0;
      #1;
      total++;
      if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err} !== {2'b10, 32'd0, 1'b0}) begin
         bad++; $display("FAIL write_rsp: valid=%b rdata=%h err=%b", bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err);
      end
      tick();
   endtask

   task automatic test_timeout();
      bus_a.rq_valid = 2'b01; bus_a.rq_addr = 64'h0000_0000_0000_0300; bus_a.rq_we = 2'b00;
      tick();
      m_last = 0;
      bus_a.rq_valid = 2'b00; bus_a.mem_ready = 1'b1;
      tick();
      bus_a.mem_ready = 1'b0;
      for (int j = 1; j <= T_A; j++) begin
         #1;
         total++;
         if ({bus_a.rsp_valid, bus_a.busy} !== 3'b001) begin
            bad++; $display("FAIL timeout_wait j=%0d: rsp_valid=%b busy=%b", j, bus_a.rsp_valid, bus_a.busy);
         end
         tick();
      end
      #1;
      total++;
      if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, bus_a.busy} !== {2'b01, 32'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL timeout_rsp: valid=%b rdata=%h err=%b busy=%b", bus_a.rsp_valid,
                         bus_a.rsp_rdata, bus_a.rsp_err, bus_a.busy);
      end
      bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_rdata = 32'h5555_0000;
      tick();
      bus_a.mem_rsp_valid = 1'b0;
      tick();
      total++;
      if ({bus_a.rsp_valid, bus_a.rsp_err, bus_a.busy, bus_a.mem_valid} !== 5'b0) begin
         bad++; $display("FAIL timeout_late_ignored: rsp_valid=%b err=%b busy=%b", bus_a.rsp_valid,
                         bus_a.rsp_err, bus_a.busy);
      end
   endtask

   task automatic test_simultaneous();
      bus_b.rq_valid = 2'b01; bus_b.rq_addr = 64'h0000_0000_0000_0040; bus_b.rq_we = 2'b00;
      tick();
      bus_b.rq_valid = 2'b00; bus_b.mem_ready = 1'b1;
      tick();
      bus_b.mem_ready = 1'b0;
      tick(); tick();
      bus_b.mem_rsp_valid = 1'b1; bus_b.mem_rsp_rdata = 32'hAAAA_5555;
      tick();
      bus_b.mem_rsp_valid = 1'b0;
      #1;
      total++;
      if ({bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.rsp_err} !== {2'b01, 32'hAAAA_5555, 1'b0}) begin
         bad++; $display("FAIL simul_rsp: valid=%b rdata=%h err=%b", bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.rsp_err);
      end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         int          v, own, w, k, nrsp;
         logic [63:0] addr, wd;
         logic [1:0]  we2, exp_g;
         logic [31:0] exp_addr, exp_wd, rd, exp_rd;
         logic        exp_we, err;
         v = $urandom_range(1, 3);
         addr = {$urandom, $urandom}; wd = {$urandom, $urandom}; we2 = 2'($urandom);
         exp_g = (v == 1) ? 2'b01 : (v == 2) ? 2'b10 : ((m_last == 1) ? 2'b01 : 2'b10);
         own = exp_g[1] ? 1 : 0;
         exp_addr = own ? addr[63:32] : addr[31:0];
         exp_wd   = own ? wd[63:32] : wd[31:0];
         exp_we   = we2[own];
         bus_a.rq_valid = 2'(v); bus_a.rq_addr = addr; bus_a.rq_we = we2; bus_a.rq_wdata = wd;
         bus_a.mem_rsp_valid = 1'($urandom_range(0, 1));
         #1;
         total++;
         if (bus_a.rq_ready !== exp_g) begin
            bad++; $display("FAIL rnd_grant n=%0d: got %b required %b", n, bus_a.rq_ready, exp_g);
         end
         tick();
         m_last = own;
         bus_a.rq_valid = 2'b00; bus_a.rq_addr = {$urandom, $urandom}; bus_a.rq_wdata = {$urandom, $urandom};
         bus_a.rq_we = 2'($urandom);
         w = $urandom_range(0, 3);
         k = $urandom_range(1, 6);
         for (int c = 0; c <= w; c++) begin
            bus_a.mem_ready = (c == w);
            bus_a.mem_rsp_valid = 1'($urandom_range(0, 1));
            #1;
            total++;
            if ({bus_a.mem_valid, bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata, bus_a.busy} !==
                {1'b1, exp_addr, exp_we, exp_wd, 1'b1}) begin
               bad++; $display("FAIL rnd_cmd n=%0d c=%0d: addr=%h we=%b wdata=%h required %h %b %h", n, c,
                               bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata, exp_addr, exp_we, exp_wd);
            end
            tick();
         end
         nrsp = (k < T_A) ? k : T_A;
         rd = '0;
         for (int j = 1; j <= nrsp; j++) begin
            bus_a.mem_ready = 1'($urandom_range(0, 1));
            bus_a.mem_rsp_valid = (j == k);
            rd = $urandom;
            bus_a.mem_rsp_rdata = rd;
            #1;
            total++;
            if ({bus_a.mem_valid, bus_a.rsp_valid, bus_a.busy} !== 4'b0001) begin
               bad++; $display("FAIL rnd_wait n=%0d j=%0d: mem_valid=%b rsp_valid=%b busy=%b", n, j,
                               bus_a.mem_valid, bus_a.rsp_valid, bus_a.busy);
            end
            tick();
         end
         bus_a.mem_rsp_valid = 1'b0; bus_a.mem_ready = 1'b0;
         err = (k > T_A);
         exp_rd = (err || exp_we) ? 32'd0 : rd;
         #1;
         total++;
         if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, bus_a.busy} !== {exp_g, exp_rd, err, 1'b0}) begin
            bad++; $display("FAIL rnd_rsp n=%0d: valid=%b rdata=%h err=%b required %b %h %b", n,
                            bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, exp_g, exp_rd, err);
         end
         tick();
         total++;
         if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err} !== '0) begin
            bad++; $display("FAIL rnd_pulse_end n=%0d: valid=%b rdata=%h err=%b", n,
                            bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [135:0] outs;
      bus_a.rq_valid = 2'b01; bus_a.rq_addr = 64'h0000_0B00_0000_0A00; bus_a.rq_we = 2'b00;
      tick();
      bus_a.rq_valid = 2'b00; bus_a.mem_ready = 1'b1;
      tick();
      bus_a.mem_ready = 1'b0;
      tick();
      #2;
      bus_a.rq_valid = 2'b11;
      reset = 1'b1;
      #1;
      outs = {bus_a.rq_ready, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, bus_a.mem_valid,
              bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata, bus_a.busy};
      total++;
      if (outs !== '0) begin
         bad++; $display("FAIL reset_mid_outputs: got %h required 0", outs);
      end
      tick(); tick();
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if ({bus_a.rq_ready, bus_a.rsp_valid} !== 4'b0100) begin
         bad++; $display("FAIL reset_first_grant: rq_ready=%b rsp_valid=%b required 01 00",
                         bus_a.rq_ready, bus_a.rsp_valid);
      end
      tick();
      bus_a.rq_valid = 2'b00;
      total++;
      if ({bus_a.rsp_valid, bus_a.mem_valid, bus_a.mem_addr} !== {2'b00, 1'b1, 32'h0000_0A00}) begin
         bad++; $display("FAIL reset_after_cmd: rsp_valid=%b mem_valid=%b addr=%h",
                         bus_a.rsp_valid, bus_a.mem_valid, bus_a.mem_addr);
      end
      bus_a.mem_ready = 1'b1;
      tick();
      bus_a.mem_ready = 1'b0; bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_rdata = 32'h0BAD_F00D;
      tick();
      bus_a.mem_rsp_valid = 1'b0;
      #1;
      total++;
      if ({bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err} !== {2'b01, 32'h0BAD_F00D, 1'b0}) begin
         bad++; $display("FAIL reset_after_rsp: valid=%b rdata=%h err=%b", bus_a.rsp_valid,
                         bus_a.rsp_rdata, bus_a.rsp_err);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_contention();
      test_single_read();
      test_write_bp();
      test_timeout();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch (requester 0) and data load/store (requester 1).
- Sits between the core's instr_addr / data_addr / should_read_mem / should_write_mem signals and a single variable-latency memory.
- Round-robin arbitration, at most one outstanding transaction.
- Per-transaction response timeout that returns an error instead of hanging the core.

Parameters:
TIMEOUT, 255, max cycles in RSP waiting for mem_rsp_valid; 0 disables the timeout; legal range 0..65535.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
rq_valid  input  2  bit i = requester i has a pending request
rq_addr  input  64  [31:0] requester 0 address, [63:32] requester 1 address
rq_we  input  2  bit i = 1: write, 0: read
rq_wdata  input  64  [31:0] requester 0 write data, [63:32] requester 1 write data
rq_ready  output  2  one-hot accept pulse to the granted requester
rsp_valid  output  2  one-hot response pulse to the transaction owner
rsp_rdata  output  32  read data; 0 for writes and on timeout
rsp_err  output  1  qualifies rsp_valid; 1 = transaction timed out
mem_valid  output  1  command valid to memory
mem_ready  input  1  memory accepts the command when mem_valid=1 and mem_ready=1
mem_addr  output  32  command address
mem_we  output  1  command write enable
mem_wdata  output  32  command write data
mem_rsp_valid  input  1  memory response strobe; also the completion ack for writes
mem_rsp_rdata  input  32  memory read data
busy  output  1  state != IDLE

Behaviour:
- Reset (async):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), owner=0, timeout counter=0.
  - All outputs 0.
  - Reset mid-transaction abandons the transaction silently; no rsp_valid is produced.
- States: IDLE, CMD, RSP.
- IDLE, arbitration:
  - rq_ready is combinational from rq_valid and last_grant.
  - One requester valid: grant it.
  - Both valid: grant the requester != last_grant.
  - On the granting edge, latch addr/we/wdata/owner, set last_grant=owner, go to CMD.
  - Requesters must hold their request fields stable only during the rq_ready cycle.
- CMD:
  - mem_valid=1; mem_addr/mem_we/mem_wdata driven from the latched registers and held stable until accepted.
  - On mem_valid & mem_ready: go to RSP and clear the timeout counter.
  - mem_rsp_valid is ignored in CMD; memory must respond no earlier than the cycle after accept.
- RSP:
  - mem_valid=0; counter increments each cycle.
  - mem_rsp_valid=1: on that edge register rsp_valid[owner]=1, rsp_rdata = (latched we ? 0 : mem_rsp_rdata), rsp_err=0; go to IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: rsp_valid[owner]=1, rsp_rdata=0, rsp_err=1; go to IDLE.
  - mem_rsp_valid on the same cycle the timeout fires: the response wins (rsp_err=0).
- Response outputs:
  - rsp_valid, rsp_rdata and rsp_err are registered; rsp_valid is a single-cycle pulse.
  - rsp_rdata and rsp_err return to 0 the cycle after the pulse.
- Back-to-back operation: the response-pulse cycle is an IDLE cycle, so a new grant can occur in the same cycle rsp_valid is high.
- Latency, both memory signals in 0-wait-state form (accept at edge E0, mem_ready=1 in the first CMD cycle, mem_rsp_valid in the first RSP cycle):
  - mem_valid high for the cycle after E0.
  - rsp_valid high 2 cycles after E0.
  - Minimum total of 3 cycles per transaction including the IDLE/grant cycle.
- mem_rsp_valid in IDLE is ignored, with no state change.
- Requester deasserting rq_valid after grant has no effect; the transaction completes.
- Counter is 16 bits and never wraps, because TIMEOUT <= 65535 bounds it.

Test Plan:
- Single read: requester 0 reads 0x00000100; memory ready=1, returns 0x12345678 the cycle after accept -> rq_ready=2'b01 in grant cycle; mem_valid one cycle with mem_addr=0x100, mem_we=0; rsp_valid=2'b01, rsp_rdata=0x12345678, rsp_err=0, 2 cycles after grant edge.
- Contention: both requesters valid continuously from reset, each transaction 0-wait -> grants alternate 0,1,0,1; each rsp_valid bit goes to the matching owner; never two grants before a response.
- Write with backpressure: requester 1 writes 0xCAFEF00D to 0x2000; mem_ready held low 4 cycles -> mem_valid/mem_addr/mem_wdata stable all 5 CMD cycles; mem_rsp_valid ack -> rsp_valid=2'b10, rsp_rdata=0, rsp_err=0.
- Timeout with TIMEOUT=4: command accepted, no mem_rsp_valid -> rsp_valid pulse with rsp_err=1 and rsp_rdata=0 exactly 4 RSP cycles after accept; busy drops. A late mem_rsp_valid afterwards in IDLE is ignored.
- Simultaneous timeout and response with TIMEOUT=3: mem_rsp_valid arrives on the 3rd RSP cycle with 0xAAAA5555 -> rsp_err=0, rsp_rdata=0xAAAA5555.
- Async reset asserted mid-RSP -> all outputs 0 immediately without a clock; after release no rsp_valid appears; with both requesters valid, the first grant goes to requester 0.
